// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and drain sequencer feeding the UART transmitter
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_TO    = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  clr_ovf,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Wide enough to hold BUSY_TO, and never zero bits wide
    localparam int TO_W  = $clog2(BUSY_TO + 2);

    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [TO_W-1:0]       TO_ONE   = 1;
    localparam logic [TO_W-1:0]       TO_LIMIT = BUSY_TO[TO_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wp_q, wp_d;
    logic [DEPTH_LOG2-1:0]   rp_q, rp_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    tx_start_q, tx_start_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

    logic                    push;
    logic                    pop;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    // A push is only taken when there is room; a pop happens whenever the sequencer is idle with data
    assign push = wr_en && !full;
    assign pop  = (state_q == S_IDLE) && !empty;

    // Write pointer, occupancy and sticky overflow; a rejected push beats clr_ovf
    always_comb begin
        wp_d       = wp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Drain sequencer: pop into tx_data, pulse START, then wait for BUSY to rise and fall (or time out)
    always_comb begin
        state_d    = state_q;
        rp_d       = rp_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        to_cnt_d   = to_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_data_d  = mem_q[rp_q];
                    rp_d       = rp_q + PTR_ONE;
                    tx_start_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (to_cnt_q == TO_LIMIT) begin
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte storage; contents are meaningless after reset since the pointers restart
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // UART model: BUSY rises on the second edge after START is seen, stays high m_len cycles
    logic model_en  = 1'b0;
    logic hold_busy = 1'b0;
    int   m_len     = 4;
    logic m_busy    = 1'b0;
    logic m_pend    = 1'b0;
    int   m_cnt     = 0;

    // Pulse log and protocol monitors
    logic [7:0] got_data[$];
    int         got_cyc[$];
    int         b2b_cnt    = 0;
    int         glitch_cnt = 0;
    logic       prev_start = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_rstn  = 1'b0;

    uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_TO(15)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = m_busy | hold_busy;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!model_en) begin
            m_busy <= 1'b0;
            m_pend <= 1'b0;
        end else if (m_pend) begin
            m_busy <= 1'b1;
            m_pend <= 1'b0;
            m_cnt  <= m_len - 1;
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end else if (tx_start) begin
            m_pend <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (tx_start) begin
            got_data.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
        if (tx_start && prev_start) b2b_cnt <= b2b_cnt + 1;
        if (reset_n && prev_rstn && !tx_start && tx_data !== prev_data) glitch_cnt <= glitch_cnt + 1;
        prev_start <= tx_start;
        prev_data  <= tx_data;
        prev_rstn  <= reset_n;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 2000 && quiet < 25; i++) begin
            tick();
            quiet = (empty && !tx_busy && !tx_start) ? quiet + 1 : 0;
        end
        n_checks++;
        if (quiet < 25) begin n_fail++; $display("FAIL settle: quiet cycles %0d, required 25", quiet); end
    endtask

    task automatic test_reset();
        int st;
        n_checks++; if (count !== 5'd0)   begin n_fail++; $display("FAIL rst_count: got %0d exp 0", count); end
        n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL rst_empty: got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL rst_full: got %b exp 0", full); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h exp 00", tx_data); end
        wr_en = 1'b1; wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_en = 1'b0;
        n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h11 || count !== 5'd1) begin
            n_fail++; $display("FAIL pre_reset: start %b data %h count %0d, exp 1 11 1", tx_start, tx_data, count);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL async_tx_start: got %b exp 0", tx_start); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL async_tx_data: got %h exp 00", tx_data); end
        n_checks++; if (count !== 5'd0)    begin n_fail++; $display("FAIL async_count: got %0d exp 0", count); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL async_flags: empty %b full %b ovf %b, exp 1 0 0", empty, full, overflow);
        end
        tick();
        reset_n = 1'b1;
        st = got_data.size();
        repeat (100) tick();
        n_checks++; if (got_data.size() != st) begin
            n_fail++; $display("FAIL idle_after_reset: pulses %0d exp 0", got_data.size() - st);
        end
    endtask

    task automatic test_single_byte();
        int st, pc, bad;
        model_en = 1'b1; m_len = 50;
        st = got_data.size();
        wr_en = 1'b1; wr_data = 8'hA5; tick();
        wr_en = 1'b0; pc = cyc;
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d exp 1", count); end
        tick();
        n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL single_start: start %b data %h, exp 1 a5", tx_start, tx_data);
        end
        for (int i = 0; i < 10 && !tx_busy; i++) tick();
        bad = 0;
        for (int i = 0; i < 100 && tx_busy; i++) begin
            if (tx_data !== 8'hA5) bad++;
            tick();
        end
        n_checks++; if (bad != 0 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL single_hold: unstable cycles %0d busy %b, exp 0 0", bad, tx_busy);
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b exp 1", empty); end
        n_checks++; if (got_data.size() - st != 1) begin
            n_fail++; $display("FAIL single_pulses: got %0d exp 1", got_data.size() - st);
        end else if (got_cyc[st] != pc + 1) begin
            n_fail++; $display("FAIL single_latency: got %0d exp %0d", got_cyc[st] - pc, 1);
        end
        settle();
    endtask

    task automatic test_burst_order();
        int st, bad_d, bad_s;
        model_en = 1'b1; m_len = 8;
        st = got_data.size();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 600 && got_data.size() < st + 16; i++) tick();
        n_checks++; if (got_data.size() != st + 16) begin
            n_fail++; $display("FAIL burst_pulses: got %0d exp 16", got_data.size() - st);
        end else begin
            bad_d = 0; bad_s = 0;
            for (int i = 0; i < 16; i++) if (got_data[st + i] !== 8'(i)) bad_d++;
            for (int i = 1; i < 16; i++) if (got_cyc[st + i] - got_cyc[st + i - 1] != 12) bad_s++;
            n_checks++; if (bad_d != 0) begin n_fail++; $display("FAIL burst_order: wrong bytes %0d exp 0", bad_d); end
            n_checks++; if (bad_s != 0) begin n_fail++; $display("FAIL burst_spacing: wrong gaps %0d exp 0", bad_s); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL burst_ovf: got %b exp 0", overflow); end
        settle();
    endtask

    task automatic test_overflow();
        int st, bad_d;
        model_en = 1'b0; hold_busy = 1'b1;
        st = got_data.size();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i); tick();
        end
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_at_cap: count %0d full %b ovf %b, exp 16 1 0", count, full, overflow);
        end
        wr_en = 1'b1; wr_data = 8'h51; tick();
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
            n_fail++; $display("FAIL ovf_set: ovf %b count %0d, exp 1 16", overflow, count);
        end
        wr_en = 1'b1; wr_data = 8'h52; clr_ovf = 1'b1; tick();
        wr_en = 1'b0; clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_priority: got %b exp 1", overflow); end
        clr_ovf = 1'b1; tick();
        clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
        model_en = 1'b1; m_len = 4; hold_busy = 1'b0;
        for (int i = 0; i < 600 && got_data.size() < st + 17; i++) tick();
        n_checks++; if (got_data.size() != st + 17) begin
            n_fail++; $display("FAIL ovf_pulses: got %0d exp 17", got_data.size() - st);
        end else begin
            bad_d = 0;
            for (int i = 0; i < 17; i++) if (got_data[st + i] !== 8'(8'h40 + i)) bad_d++;
            n_checks++; if (bad_d != 0) begin n_fail++; $display("FAIL ovf_order: wrong bytes %0d exp 0", bad_d); end
        end
        settle();
        n_checks++; if (got_data.size() != st + 17) begin
            n_fail++; $display("FAIL ovf_no_extra: got %0d exp 17", got_data.size() - st);
        end
    endtask

    task automatic test_full_push_pop();
        int st;
        model_en = 1'b0; hold_busy = 1'b1;
        st = got_data.size();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i); tick();
        end
        wr_en = 1'b0;
        hold_busy = 1'b0; tick();
        n_checks++; if (full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL pp_before: full %b ovf %b, exp 1 0", full, overflow);
        end
        wr_en = 1'b1; wr_data = 8'h7F; tick();
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL pp_ovf: got %b exp 1", overflow); end
        n_checks++; if (count !== 5'd15 || full !== 1'b0) begin
            n_fail++; $display("FAIL pp_count: count %0d full %b, exp 15 0", count, full);
        end
        n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h61) begin
            n_fail++; $display("FAIL pp_pop: start %b data %h, exp 1 61", tx_start, tx_data);
        end
        clr_ovf = 1'b1; tick();
        clr_ovf = 1'b0;
        model_en = 1'b1; m_len = 4;
        for (int i = 0; i < 800 && got_data.size() < st + 17; i++) tick();
        n_checks++; if (got_data.size() != st + 17) begin
            n_fail++; $display("FAIL pp_pulses: got %0d exp 17", got_data.size() - st);
        end else if (got_data[st + 16] !== 8'h70) begin
            n_fail++; $display("FAIL pp_last: got %h exp 70", got_data[st + 16]);
        end
        settle();
    endtask

    task automatic test_busy_timeout();
        int st;
        model_en = 1'b0; hold_busy = 1'b0;
        st = got_data.size();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h91 + i); tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 200 && got_data.size() < st + 3; i++) tick();
        n_checks++; if (got_data.size() != st + 3) begin
            n_fail++; $display("FAIL to_pulses: got %0d exp 3", got_data.size() - st);
        end else begin
            n_checks++; if (got_cyc[st + 1] - got_cyc[st] != 18 || got_cyc[st + 2] - got_cyc[st + 1] != 18) begin
                n_fail++; $display("FAIL to_period: gaps %0d %0d exp 18 18",
                                   got_cyc[st + 1] - got_cyc[st], got_cyc[st + 2] - got_cyc[st + 1]);
            end
            n_checks++; if (got_data[st] !== 8'h91 || got_data[st + 1] !== 8'h92 || got_data[st + 2] !== 8'h93) begin
                n_fail++; $display("FAIL to_order: got %h %h %h exp 91 92 93", got_data[st], got_data[st + 1], got_data[st + 2]);
            end
        end
        settle();
        n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin
            n_fail++; $display("FAIL to_empty: empty %b count %0d, exp 1 0", empty, count);
        end
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        test_reset();
        test_single_byte();
        test_burst_order();
        test_overflow();
        test_full_push_pop();
        test_busy_timeout();
        n_checks++; if (b2b_cnt != 0) begin n_fail++; $display("FAIL start_consecutive: got %0d exp 0", b2b_cnt); end
        n_checks++; if (glitch_cnt != 0) begin n_fail++; $display("FAIL data_unstable: got %0d exp 0", glitch_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and drain sequencer between the command controller and the UART transmitter. The controller pushes response bytes at any rate; this block buffers them and hands them one at a time to the UART_TX START/DATA/BUSY interface, so bursts (e.g. multi-byte I2C read results) never stall the controller or drop bytes silently. It sits directly downstream of the controller's `o_data_uart` / `o_uart_tx_start` outputs and directly upstream of UART_TX.

## Interface
- `DEPTH_LOG2`, 4, log2 of FIFO depth (depth = 16 bytes).
- `BUSY_TO`, 15, cycles to wait for `tx_busy` to rise after `tx_start` before the byte is treated as sent.

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `wr_en`  in  1  push strobe from controller, one byte per high cycle.
- `wr_data`  in  8  byte to push.
- `clr_ovf`  in  1  clears sticky `overflow`.
- `tx_busy`  in  1  UART_TX BUSY.
- `tx_start`  out  1  UART_TX START, single-cycle pulse.
- `tx_data`  out  8  UART_TX DATA, held stable from `tx_start` until the byte completes.
- `full`  out  1  count == 2^DEPTH_LOG2.
- `empty`  out  1  count == 0.
- `count`  out  DEPTH_LOG2+1  bytes currently stored; excludes the byte in flight.
- `overflow`  out  1  sticky: a push was rejected because FIFO was full.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array; write and read pointers DEPTH_LOG2 bits, wrap modulo depth; `count` kept as a separate register.
- Push: accepted iff `wr_en` and `full` is low at that edge; writes `mem[wp]`, increments `wp`. A push while full is discarded and sets `overflow`, including when a pop happens in the same cycle.
- Push and pop in the same cycle: `count` unchanged; both pointers advance.
- `overflow` clears on `clr_ovf`; a simultaneous rejected push takes priority, so `overflow` stays 1.
- Drain FSM states:
  - IDLE: if `!empty`, perform the pop: `tx_data <= mem[rp]`, increment `rp`, `tx_start <= 1`, go to START.
  - START: `tx_start <= 0`, clear the timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy` is high, go to WAIT_DONE. Otherwise, when the timeout counter reaches BUSY_TO, go to IDLE. Otherwise increment the counter.
  - WAIT_DONE: when `tx_busy` is low, go to IDLE.
- `tx_data` changes only on a pop.
- `tx_busy` high while in IDLE does not block a pop. UART_TX ignores START while busy, so the FSM never enters IDLE while its own byte is active.
- Reset values: `tx_start` 0, `tx_data` 8'h00, `full` 0, `empty` 1, `count` 0, `overflow` 0, pointers 0, FSM in IDLE, timeout counter 0.
- Reset mid-operation: all FIFO contents are lost. A byte already being shifted by UART_TX is not aborted by this block.

## Timing
- `full`, `empty` and `count` are registered and reflect pushes and pops from the previous edge.
- Latency, empty FIFO and IDLE: `wr_en` sampled at edge n, `count` = 1 after edge n, `tx_start` high for the cycle after edge n+1. Push to start is 2 cycles.
- `tx_start` is high for exactly 1 cycle per popped byte, and never in consecutive cycles.
- Minimum spacing between two `tx_start` pulses is 4 cycles (IDLE, START, WAIT_BUSY, WAIT_DONE, IDLE) when `tx_busy` rises immediately. The typical gap is bounded by the UART frame time.
- With `tx_busy` stuck low, the pulse period is BUSY_TO + 3 cycles and the FIFO still drains.
- Throughput: one byte per UART frame; the FIFO absorbs bursts up to 2^DEPTH_LOG2 bytes beyond the in-flight byte.

## Test plan
- Reset then idle: `reset_n` low asynchronously mid-cycle -> outputs take reset values immediately; after release, `tx_start` stays 0 for 100 cycles.
- Single byte: push 8'hA5 with a UART model that raises BUSY 2 cycles after START for 50 cycles -> one `tx_start` pulse 2 cycles after the push, `tx_data` = A5 stable until BUSY falls, `empty` = 1 afterwards.
- Burst order: push 00..0F back-to-back while the UART is busy -> bytes emitted in order 00..0F, one `tx_start` per BUSY fall, `overflow` = 0.
- Overflow: hold the UART busy and push 18 bytes -> `count` saturates at 16 with `full` = 1; `overflow` = 1 after the 17th push accepted past capacity; pulse `clr_ovf` -> `overflow` = 0. Byte order is unaffected.
- Simultaneous push and pop at full: arrange a pop on the same edge as a push while `full` = 1 -> push rejected, `overflow` = 1, `count` = 15.
- Busy timeout: `tx_busy` tied low, push 3 bytes -> 3 `tx_start` pulses spaced BUSY_TO + 3 = 18 cycles apart; the FIFO ends empty.
